// File: rtl/neosd_cmd_ctrl.sv
// SD CMD-line controller: shifts out one 48-bit command frame with CRC7, then
// optionally receives a 48-bit or 136-bit response, one bit per qualified SD clock tick.
module neosd_cmd_ctrl #(
  parameter int NCR_MAX   = 64,
  parameter int NCC_TICKS = 8
) (
  input  logic         clk_i,
  input  logic         rstn_i,
  input  logic         clkstrb_i,
  input  logic         sd_clk_en_i,
  input  logic         start_i,
  input  logic [5:0]   cmd_idx_i,
  input  logic [31:0]  cmd_arg_i,
  input  logic [1:0]   rsp_type_i,
  output logic         sd_clk_req_o,
  output logic         sd_cmd_o,
  output logic         sd_cmd_oe_o,
  input  logic         sd_cmd_i,
  output logic         busy_o,
  output logic         done_o,
  output logic         crc_err_o,
  output logic         timeout_o,
  output logic [5:0]   rsp_idx_o,
  output logic [127:0] rsp_o
);

  typedef enum logic [2:0] {S_IDLE, S_TX, S_WAIT, S_RX, S_NCC} state_t;

  localparam logic [7:0] NCR_LAST = 8'(NCR_MAX - 1);
  localparam logic [7:0] NCC_LAST = 8'(NCC_TICKS - 1);

  state_t         state_q, state_d;
  logic [7:0]     cnt_q, cnt_d;
  logic [39:0]    tx_shift_q, tx_shift_d;
  logic [6:0]     crc_q, crc_d;
  logic [1:0]     rsp_type_q, rsp_type_d;
  logic [127:0]   rx_shift_q, rx_shift_d;
  logic           sd_cmd_q, sd_cmd_d;
  logic           sd_cmd_oe_q, sd_cmd_oe_d;
  logic           done_q, done_d;
  logic           crc_err_q, crc_err_d;
  logic           timeout_q, timeout_d;
  logic [5:0]     rsp_idx_q, rsp_idx_d;
  logic [127:0]   rsp_q, rsp_d;

  logic           tick;
  logic [127:0]   rx_next;
  logic [7:0]     rx_last;
  logic           rx_in_crc;

  // Serial CRC7 (x^7 + x^3 + 1), MSB first.
  function automatic logic [6:0] crc7_step(input logic [6:0] crc, input logic din);
    logic fb;
    fb = din ^ crc[6];
    return {crc[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
  endfunction

  assign tick    = clkstrb_i & sd_clk_en_i;
  assign rx_next = {rx_shift_q[126:0], sd_cmd_i};
  assign rx_last = (rsp_type_q == 2'b10) ? 8'd134 : 8'd46;
  // Long responses exclude the 8 header bits from CRC coverage.
  assign rx_in_crc = (rsp_type_q == 2'b10) ? ((cnt_q >= 8'd7) && (cnt_q <= 8'd126))
                                           : (cnt_q <= 8'd38);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    tx_shift_d  = tx_shift_q;
    crc_d       = crc_q;
    rsp_type_d  = rsp_type_q;
    rx_shift_d  = rx_shift_q;
    sd_cmd_d    = sd_cmd_q;
    sd_cmd_oe_d = sd_cmd_oe_q;
    done_d      = 1'b0;
    crc_err_d   = crc_err_q;
    timeout_d   = timeout_q;
    rsp_idx_d   = rsp_idx_q;
    rsp_d       = rsp_q;

    unique case (state_q)
      S_IDLE: begin
        if (start_i) begin
          tx_shift_d = {2'b01, cmd_idx_i, cmd_arg_i};
          rsp_type_d = rsp_type_i;
          crc_err_d  = 1'b0;
          timeout_d  = 1'b0;
          crc_d      = 7'h00;
          cnt_d      = 8'd0;
          state_d    = S_TX;
        end
      end

      S_TX: begin
        if (tick) begin
          cnt_d       = cnt_q + 8'd1;
          sd_cmd_oe_d = 1'b1;
          if (cnt_q < 8'd40) begin
            sd_cmd_d   = tx_shift_q[39];
            crc_d      = crc7_step(crc_q, tx_shift_q[39]);
            tx_shift_d = {tx_shift_q[38:0], 1'b0};
          end else if (cnt_q < 8'd47) begin
            sd_cmd_d = crc_q[6];
            crc_d    = {crc_q[5:0], 1'b0};
          end else if (cnt_q == 8'd47) begin
            sd_cmd_d = 1'b1;
          end else begin
            sd_cmd_oe_d = 1'b0;
            sd_cmd_d    = 1'b1;
            cnt_d       = 8'd0;
            state_d     = (rsp_type_q == 2'b00) ? S_NCC : S_WAIT;
          end
        end
      end

      S_WAIT: begin
        if (tick) begin
          if (!sd_cmd_i) begin
            rx_shift_d = rx_next;
            crc_d      = 7'h00;
            cnt_d      = 8'd0;
            state_d    = S_RX;
          end else if (cnt_q == NCR_LAST) begin
            timeout_d = 1'b1;
            cnt_d     = 8'd0;
            state_d   = S_NCC;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end
      end

      S_RX: begin
        if (tick) begin
          rx_shift_d = rx_next;
          cnt_d      = cnt_q + 8'd1;
          if (rx_in_crc) begin
            crc_d = crc7_step(crc_q, sd_cmd_i);
          end
          if ((cnt_q == 8'd0) && sd_cmd_i) begin
            crc_err_d = 1'b1;
          end
          if (cnt_q == rx_last) begin
            if (!sd_cmd_i || ((rsp_type_q != 2'b11) && (crc_q != rx_next[7:1]))) begin
              crc_err_d = 1'b1;
            end
            if (rsp_type_q == 2'b10) begin
              rsp_d = rx_next;
            end else begin
              rsp_d     = {96'b0, rx_next[39:8]};
              rsp_idx_d = rx_next[45:40];
            end
            cnt_d   = 8'd0;
            state_d = S_NCC;
          end
        end
      end

      S_NCC: begin
        if (tick) begin
          if (cnt_q == NCC_LAST) begin
            cnt_d   = 8'd0;
            done_d  = 1'b1;
            state_d = S_IDLE;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q     <= S_IDLE;
      cnt_q       <= 8'd0;
      tx_shift_q  <= '0;
      crc_q       <= 7'h00;
      rsp_type_q  <= 2'b00;
      rx_shift_q  <= '0;
      sd_cmd_q    <= 1'b1;
      sd_cmd_oe_q <= 1'b0;
      done_q      <= 1'b0;
      crc_err_q   <= 1'b0;
      timeout_q   <= 1'b0;
      rsp_idx_q   <= 6'd0;
      rsp_q       <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      tx_shift_q  <= tx_shift_d;
      crc_q       <= crc_d;
      rsp_type_q  <= rsp_type_d;
      rx_shift_q  <= rx_shift_d;
      sd_cmd_q    <= sd_cmd_d;
      sd_cmd_oe_q <= sd_cmd_oe_d;
      done_q      <= done_d;
      crc_err_q   <= crc_err_d;
      timeout_q   <= timeout_d;
      rsp_idx_q   <= rsp_idx_d;
      rsp_q       <= rsp_d;
    end
  end

  assign busy_o       = (state_q != S_IDLE);
  assign sd_clk_req_o = (state_q != S_IDLE);
  assign sd_cmd_o     = sd_cmd_q;
  assign sd_cmd_oe_o  = sd_cmd_oe_q;
  assign done_o       = done_q;
  assign crc_err_o    = crc_err_q;
  assign timeout_o    = timeout_q;
  assign rsp_idx_o    = rsp_idx_q;
  assign rsp_o        = rsp_q;

endmodule

// File: tb/tb_neosd_cmd_ctrl.sv
// Self-checking bench for neosd_cmd_ctrl: a tick-level card model drives the CMD
// line and a frame-level reference model predicts TX bits, timing, flags and responses.
module tb_neosd_cmd_ctrl;

  localparam int NCR_MAX   = 64;
  localparam int NCC_TICKS = 8;

  logic         clk = 1'b0;
  logic         rstn = 1'b1;
  logic         clkStrb = 1'b0;
  logic         sdClkEn = 1'b0;
  logic         start = 1'b0;
  logic [5:0]   cmdIdx = '0;
  logic [31:0]  cmdArg = '0;
  logic [1:0]   rspType = '0;
  logic         sdCmdIn = 1'b1;
  logic         sdClkReq, sdCmdOut, sdCmdOe, busy, done, crcErr, timeoutFlag;
  logic [5:0]   rspIdx;
  logic [127:0] rsp;

  int checks = 0;
  int failures = 0;

  logic [127:0] expRsp = '0;
  logic [5:0]   expIdx = '0;

  int gapMin = 0;
  int gapMax = 2;
  int stallAt = -1;
  int resetAt = -1;
  bit noiseOn = 1'b1;
  bit pulseWhileBusy = 1'b0;

  int          tickIdx, timeoutTick, doneTick, doneCount, oeLeak;
  logic [47:0] txCap, oeCap;
  logic        relCmd, relOe;

  neosd_cmd_ctrl #(.NCR_MAX(NCR_MAX), .NCC_TICKS(NCC_TICKS)) dut (
    .clk_i(clk), .rstn_i(rstn), .clkstrb_i(clkStrb), .sd_clk_en_i(sdClkEn),
    .start_i(start), .cmd_idx_i(cmdIdx), .cmd_arg_i(cmdArg), .rsp_type_i(rspType),
    .sd_clk_req_o(sdClkReq), .sd_cmd_o(sdCmdOut), .sd_cmd_oe_o(sdCmdOe), .sd_cmd_i(sdCmdIn),
    .busy_o(busy), .done_o(done), .crc_err_o(crcErr), .timeout_o(timeoutFlag),
    .rsp_idx_o(rspIdx), .rsp_o(rsp)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // CRC7 as the remainder of M(x)*x^7 divided by x^7+x^3+1, over data[hi:lo].
  function automatic logic [6:0] crc7Div(input logic [135:0] data, input int hi, input int lo);
    logic [7:0] r;
    r = 8'h00;
    for (int i = hi; i >= lo - 7; i--) begin
      r = {r[6:0], (i >= lo) ? data[i] : 1'b0};
      if (r[7]) r = r ^ 8'h89;
    end
    return r[6:0];
  endfunction

  function automatic logic [135:0] makeR1(input logic [5:0] idx, input logic [31:0] arg);
    logic [135:0] f;
    f = {88'b0, 2'b00, idx, arg, 7'h00, 1'b1};
    f[7:1] = crc7Div(f, 47, 8);
    return f;
  endfunction

  function automatic logic [135:0] makeR2(input logic [127:0] content);
    logic [135:0] f;
    f = {8'h3F, content};
    f[7:1] = crc7Div(f, 127, 8);
    f[0] = 1'b1;
    return f;
  endfunction

  // Card drives the start bit on WAIT tick 'delay', then the rest of the frame.
  function automatic logic cardBit(input int t, input logic [135:0] frame, input logic [1:0] rt,
                                   input int delay, input int len);
    int w;
    w = t - 48;
    if (rt == 2'b00 || delay == 0 || w < delay) return 1'b1;
    if (w == delay) return 1'b0;
    if (w - delay <= len - 1) return frame[len - 1 - (w - delay)];
    return 1'b1;
  endfunction

  task automatic observe(input bit ticked);
    int k;
    k = tickIdx - 1;
    if (ticked && k >= 0 && k < 48) begin
      txCap[47 - k] = sdCmdOut;
      oeCap[47 - k] = sdCmdOe;
    end
    if (ticked && k == 48) begin
      relCmd = sdCmdOut;
      relOe  = sdCmdOe;
    end
    if (k >= 48 && sdCmdOe) oeLeak++;
    if (timeoutFlag && timeoutTick < 0) timeoutTick = k;
    if (done) begin
      doneCount++;
      doneTick = k;
    end
  endtask

  task automatic driveCycle(input bit isTick, input logic cmdBit);
    if (isTick) begin
      clkStrb = 1'b1;
      sdClkEn = 1'b1;
      sdCmdIn = cmdBit;
    end else begin
      if (noiseOn) begin
        clkStrb = 1'($urandom_range(0, 1));
        sdClkEn = clkStrb ? 1'b0 : 1'($urandom_range(0, 1));
      end else begin
        clkStrb = 1'b0;
        sdClkEn = 1'b1;
      end
      sdCmdIn = 1'($urandom_range(0, 1));
    end
    start = pulseWhileBusy ? ($urandom_range(0, 3) == 0) : 1'b0;
    if (start) begin
      cmdIdx  = 6'($urandom);
      cmdArg  = $urandom;
      rspType = 2'($urandom);
    end
    @(negedge clk);
    if (isTick) tickIdx++;
    observe(isTick);
  endtask

  task automatic checkResetValues(input string p);
    checkOutput({p, "Cmd"}, sdCmdOut, 1'b1);
    checkOutput({p, "Oe"}, sdCmdOe, 1'b0);
    checkOutput({p, "ClkReq"}, sdClkReq, 1'b0);
    checkOutput({p, "Busy"}, busy, 1'b0);
    checkOutput({p, "Done"}, done, 1'b0);
    checkOutput({p, "CrcErr"}, crcErr, 1'b0);
    checkOutput({p, "Timeout"}, timeoutFlag, 1'b0);
    checkOutput({p, "Rsp"}, rsp, 128'h0);
    checkOutput({p, "RspIdx"}, rspIdx, 6'h0);
  endtask

  task automatic applyStimulus(input logic [5:0] idx, input logic [31:0] arg, input logic [1:0] rt,
                               input int delay, input logic [135:0] frame);
    int respLen, respTicks, totalTicks, expTimeoutTick;
    logic [47:0] expTx;
    logic [127:0] newRsp;
    logic [5:0] newIdx;
    logic expTimeout, gotResp, expCrcErr;
    bit stallDone, aborted;

    respLen = (rt == 2'b10) ? 136 : 48;
    expTx = {2'b01, idx, arg, 7'h00, 1'b1};
    expTx[7:1] = crc7Div({88'b0, expTx}, 47, 8);
    expTimeout = (rt != 2'b00) && (delay == 0);
    gotResp = (rt != 2'b00) && (delay != 0);
    if (rt == 2'b00) respTicks = 0;
    else if (expTimeout) respTicks = NCR_MAX;
    else respTicks = delay + respLen - 1;
    totalTicks = 49 + respTicks + NCC_TICKS;
    expTimeoutTick = expTimeout ? 48 + NCR_MAX : -1;
    expCrcErr = 1'b0;
    newRsp = expRsp;
    newIdx = expIdx;
    if (gotResp) begin
      expCrcErr = frame[respLen - 2] || !frame[0] ||
                  (rt != 2'b11 && ((rt == 2'b10) ? crc7Div(frame, 127, 8)
                                                 : crc7Div(frame, 47, 8)) != frame[7:1]);
      if (rt == 2'b10) newRsp = frame[127:0];
      else begin
        newRsp = {96'b0, frame[39:8]};
        newIdx = frame[45:40];
      end
    end

    start = 1'b1; cmdIdx = idx; cmdArg = arg; rspType = rt;
    clkStrb = 1'($urandom_range(0, 1)); sdClkEn = 1'($urandom_range(0, 1));
    sdCmdIn = 1'($urandom_range(0, 1));
    @(negedge clk);
    start = 1'b0; cmdIdx = 6'($urandom); cmdArg = $urandom; rspType = 2'($urandom);
    checkOutput("startBusy", busy, 1'b1);
    checkOutput("startClkReq", sdClkReq, 1'b1);
    checkOutput("startCrcErrClr", crcErr, 1'b0);
    checkOutput("startTimeoutClr", timeoutFlag, 1'b0);
    checkOutput("startDone", done, 1'b0);

    tickIdx = 0; timeoutTick = -1; doneTick = -1; doneCount = 0; oeLeak = 0;
    txCap = '0; oeCap = '0; relCmd = 1'b0; relOe = 1'b1;
    stallDone = 1'b0; aborted = 1'b0;
    while (tickIdx < totalTicks) begin
      if (tickIdx == stallAt && !stallDone) begin
        stallDone = 1'b1;
        start = 1'b0;
        repeat (20) begin
          clkStrb = 1'b1; sdClkEn = 1'b0; sdCmdIn = 1'($urandom_range(0, 1));
          @(negedge clk); observe(1'b0);
          clkStrb = 1'b0;
          @(negedge clk); observe(1'b0);
        end
      end
      repeat ($urandom_range(gapMin, gapMax)) driveCycle(1'b0, 1'b1);
      driveCycle(1'b1, cardBit(tickIdx, frame, rt, delay, respLen));
      if (tickIdx == resetAt) begin
        start = 1'b0; clkStrb = 1'b0;
        rstn = 1'b0;
        #1;
        checkResetValues("abortNow");
        @(negedge clk);
        checkResetValues("abortNext");
        rstn = 1'b1;
        repeat (3) begin
          clkStrb = 1'b1; sdClkEn = 1'b1;
          @(negedge clk);
          checkOutput("postResetNoDone", done, 1'b0);
        end
        clkStrb = 1'b0;
        expRsp = '0;
        expIdx = '0;
        aborted = 1'b1;
        break;
      end
    end

    if (!aborted) begin
      start = 1'b0; clkStrb = 1'b0;
      expRsp = newRsp;
      expIdx = newIdx;
      checkOutput("txFrame", txCap, expTx);
      checkOutput("txOe", oeCap, 48'hFFFF_FFFF_FFFF);
      checkOutput("releaseOe", relOe, 1'b0);
      checkOutput("releaseCmd", relCmd, 1'b1);
      checkOutput("oeAfterRelease", oeLeak, 0);
      checkOutput("timeoutTick", timeoutTick, expTimeoutTick);
      checkOutput("doneCount", doneCount, 1);
      checkOutput("doneTick", doneTick, totalTicks - 1);
      checkOutput("endBusy", busy, 1'b0);
      checkOutput("endClkReq", sdClkReq, 1'b0);
      checkOutput("crcErr", crcErr, expCrcErr);
      checkOutput("timeout", timeoutFlag, expTimeout);
      checkOutput("rsp", rsp, expRsp);
      checkOutput("rspIdx", rspIdx, expIdx);
      repeat ($urandom_range(0, 2)) begin
        clkStrb = 1'($urandom_range(0, 1)); sdClkEn = 1'($urandom_range(0, 1));
        @(negedge clk);
        checkOutput("donePulseOnce", done, 1'b0);
      end
      clkStrb = 1'b0;
    end
  endtask

  initial begin
    logic [135:0] good8, bad8, r2, fr;
    logic [1:0]   rt;
    int           d, len, pos;

    #1 rstn = 1'b0;
    @(negedge clk);
    $display("[TB] reset state");
    checkResetValues("reset");
    rstn = 1'b1;
    @(negedge clk);

    $display("[TB] CMD0, no response, strobe every 4 cycles");
    noiseOn = 1'b0; gapMin = 3; gapMax = 3;
    applyStimulus(6'd0, 32'h0, 2'b00, 0, '0);
    checkOutput("cmd0Tx", txCap, 48'h40_0000_0000_95);
    noiseOn = 1'b1; gapMin = 0; gapMax = 2;

    $display("[TB] CMD8 with R7 response");
    good8 = {88'b0, 48'h08_0000_01AA_13};
    applyStimulus(6'd8, 32'h0000_01AA, 2'b01, 4, good8);
    checkOutput("cmd8Tx", txCap, 48'h48_0000_01AA_87);
    checkOutput("cmd8Idx", rspIdx, 6'd8);
    checkOutput("cmd8Arg", rsp[31:0], 32'h0000_01AA);
    checkOutput("cmd8CrcErr", crcErr, 1'b0);

    $display("[TB] corrupted response argument");
    bad8 = good8 ^ 136'h1000;
    applyStimulus(6'd8, 32'h0000_01AA, 2'b01, 4, bad8);
    checkOutput("flipCrcErr", crcErr, 1'b1);
    checkOutput("flipArg", rsp[31:0], 32'h0000_01BA);
    applyStimulus(6'd8, 32'h0000_01AA, 2'b11, 4, bad8);
    checkOutput("flipNoCheck", crcErr, 1'b0);

    $display("[TB] response timeout and last-tick start bit");
    applyStimulus(6'd17, 32'h1234_5678, 2'b01, 0, '0);
    checkOutput("timeoutSet", timeoutFlag, 1'b1);
    applyStimulus(6'd8, 32'h0000_01AA, 2'b01, NCR_MAX, good8);
    checkOutput("lateStartNoTimeout", timeoutFlag, 1'b0);
    checkOutput("lateStartArg", rsp[31:0], 32'h0000_01AA);

    $display("[TB] 136-bit response");
    r2 = makeR2({$urandom, $urandom, $urandom, $urandom});
    applyStimulus(6'd2, 32'h0, 2'b10, 3, r2);
    checkOutput("r2Rsp", rsp, r2[127:0]);
    checkOutput("r2CrcErr", crcErr, 1'b0);
    r2[0] = 1'b0;
    applyStimulus(6'd2, 32'h0, 2'b10, 3, r2);
    checkOutput("r2EndBitErr", crcErr, 1'b1);

    $display("[TB] clock stall mid-TX with start pulses while busy");
    stallAt = 20; pulseWhileBusy = 1'b1;
    applyStimulus(6'd8, 32'h0000_01AA, 2'b01, 2, good8);
    stallAt = -1;

    $display("[TB] reset during reception");
    resetAt = 49 + 4 + 10;
    applyStimulus(6'd8, 32'h0000_01AA, 2'b01, 4, good8);
    resetAt = -1; pulseWhileBusy = 1'b0;
    applyStimulus(6'd0, 32'h0, 2'b00, 0, '0);
    checkOutput("recoverTx", txCap, 48'h40_0000_0000_95);

    $display("[TB] randomized transactions");
    for (int n = 0; n < 30; n++) begin
      rt = 2'($urandom);
      d = $urandom_range(0, 9);
      if (d == 0) d = 0;
      else if (d == 1) d = NCR_MAX;
      else d = $urandom_range(1, 12);
      len = (rt == 2'b10) ? 136 : 48;
      if (rt == 2'b10) fr = makeR2({$urandom, $urandom, $urandom, $urandom});
      else fr = makeR1(6'($urandom), $urandom);
      if ($urandom_range(0, 3) == 0) begin
        pos = $urandom_range(0, len - 2);
        fr[pos] = ~fr[pos];
      end
      pulseWhileBusy = ($urandom_range(0, 1) == 1);
      stallAt = ($urandom_range(0, 4) == 0) ? $urandom_range(0, 47) : -1;
      applyStimulus(6'($urandom), $urandom, rt, d, fr);
    end
    stallAt = -1; pulseWhileBusy = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
